// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, NRD comb read ports, one write port,
// write-to-read bypass and a per-register busy scoreboard for decode stalls.
//   clk/clr : clock, synchronous active-high clear
//   rn/q/busy : per-port read address, read data, scoreboard flag
//   wn/d/we : write port;  bn/bset : scoreboard set port
module regfile_mp #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int NRD     = 2,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NRD*AW-1:0]    rn,
  output logic [NRD*WIDTH-1:0] q,
  output logic [NRD-1:0]       busy,
  input  logic [AW-1:0]        wn,
  input  logic [WIDTH-1:0]     d,
  input  logic                 we,
  input  logic [AW-1:0]        bn,
  input  logic                 bset
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] sb_q;
  logic [DEPTH-1:0] sb_d;

  logic wr_ok;
  logic bs_ok;

  // Address names a real, writable register: in range and not the
  // hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic in_rng;
    in_rng = (32'(a) < 32'(DEPTH));
    return in_rng && !(ZERO_R0 && (a == '0));
  endfunction

  assign wr_ok = we && addr_ok(wn);
  assign bs_ok = bset && addr_ok(bn);

  // Next state. Busy-set is applied after the write so a new producer
  // issued in the same cycle as the old one retires keeps the reg busy.
  always_comb begin
    sb_d = sb_q;
    for (int j = 0; j < DEPTH; j++) begin
      mem_d[j] = mem_q[j];
      if (wr_ok && (wn == AW'(j))) begin
        mem_d[j] = d;
        sb_d[j]  = 1'b0;
      end
      if (bs_ok && (bn == AW'(j))) begin
        sb_d[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
      sb_q <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= mem_d[j];
      end
      sb_q <= sb_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd_q;
    logic             rd_b;

    assign ra = rn[i*AW +: AW];

    always_comb begin
      rd_q = '0;
      rd_b = 1'b0;
      if (!addr_ok(ra)) begin
        rd_q = '0;
        rd_b = 1'b0;
      end else if (BYPASS && wr_ok && (wn == ra)) begin
        rd_q = d;
        rd_b = 1'b0;
      end else begin
        rd_q = mem_q[ra];
        rd_b = sb_q[ra];
      end
    end

    assign q[i*WIDTH +: WIDTH] = rd_q;
    assign busy[i]             = rd_b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed + random checks of regfile_mp in three builds
// (default, 16x12 with 4 ports, no-bypass/no-zero-reg).
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr;

  // A: default build
  logic [9:0]  a_rn;
  logic [63:0] a_q;
  logic [1:0]  a_busy;
  logic [4:0]  a_wn, a_bn;
  logic [31:0] a_d;
  logic        a_we, a_bset;

  // B: WIDTH=16, DEPTH=12, NRD=4
  logic [15:0] b_rn;
  logic [63:0] b_q;
  logic [3:0]  b_busy;
  logic [3:0]  b_wn, b_bn;
  logic [15:0] b_d;
  logic        b_we, b_bset;

  // C: ZERO_R0=0, BYPASS=0
  logic [9:0]  c_rn;
  logic [63:0] c_q;
  logic [1:0]  c_busy;
  logic [4:0]  c_wn, c_bn;
  logic [31:0] c_d;
  logic        c_we, c_bset;

  regfile_mp u_a (
    .clk(clk), .clr(clr), .rn(a_rn), .q(a_q), .busy(a_busy),
    .wn(a_wn), .d(a_d), .we(a_we), .bn(a_bn), .bset(a_bset)
  );

  regfile_mp #(.WIDTH(16), .DEPTH(12), .NRD(4)) u_b (
    .clk(clk), .clr(clr), .rn(b_rn), .q(b_q), .busy(b_busy),
    .wn(b_wn), .d(b_d), .we(b_we), .bn(b_bn), .bset(b_bset)
  );

  regfile_mp #(.ZERO_R0(1'b0), .BYPASS(1'b0)) u_c (
    .clk(clk), .clr(clr), .rn(c_rn), .q(c_q), .busy(c_busy),
    .wn(c_wn), .d(c_d), .we(c_we), .bn(c_bn), .bset(c_bset)
  );

  int vectors = 0;
  int errs    = 0;

  // Reference model of build A: plain register array and busy array.
  logic [31:0] m_reg [32];
  logic        m_sb  [32];

  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 32; k++) begin
        m_reg[k] <= '0;
        m_sb[k]  <= 1'b0;
      end
    end else begin
      if (a_we && a_wn != 0) begin
        m_reg[a_wn] <= a_d;
        m_sb[a_wn]  <= 1'b0;
      end
      if (a_bset && a_bn != 0) m_sb[a_bn] <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_q(input logic [4:0] r);
    if (r == 0) return '0;
    if (a_we && a_wn == r) return a_d;
    return m_reg[r];
  endfunction

  function automatic logic exp_b(input logic [4:0] r);
    if (r == 0) return 1'b0;
    if (a_we && a_wn == r) return 1'b0;
    return m_sb[r];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag);
    for (int p = 0; p < 2; p++) begin
      chk({tag, "_q"}, a_q[p*32 +: 32], exp_q(a_rn[p*5 +: 5]));
      chk({tag, "_busy"}, 32'(a_busy[p]), 32'(exp_b(a_rn[p*5 +: 5])));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with a write and bset presented in the same cycle
    clr = 1'b1;
    a_rn = '0; a_wn = 5'd5; a_d = 32'h1234; a_we = 1'b1;
    a_bn = 5'd5; a_bset = 1'b1;
    b_rn = '0; b_wn = 4'd5; b_d = 16'h1234; b_we = 1'b1;
    b_bn = 4'd5; b_bset = 1'b1;
    c_rn = '0; c_wn = 5'd5; c_d = 32'h1234; c_we = 1'b1;
    c_bn = 5'd5; c_bset = 1'b1;
    tick();
    clr = 1'b0;
    a_we = 1'b0; a_bset = 1'b0;
    b_we = 1'b0; b_bset = 1'b0;
    c_we = 1'b0; c_bset = 1'b0;

    for (int r = 0; r < 32; r++) begin
      a_rn = {5'(r), 5'(r)};
      @(negedge clk);
      chk_a("reset");
      chk("reset_q_const", a_q[31:0], 32'h0);
    end
    b_rn = {4{4'd5}};
    c_rn = {5'd5, 5'd5};
    @(negedge clk);
    chk("reset_b_q", b_q[31:0], 32'h0);
    chk("reset_b_busy", 32'(b_busy), 32'h0);
    chk("reset_c_q", c_q[31:0], 32'h0);
    chk("reset_c_busy", 32'(c_busy), 32'h0);
    tick();

    // sweep writes: port0 on reg 0, port1 on the reg being written
    for (int n = 0; n < 32; n++) begin
      a_we = 1'b1; a_wn = 5'(n); a_d = 32'hffff0000 + n;
      a_rn = {5'(n), 5'd0};
      @(negedge clk);
      chk_a("sweep");
      chk("sweep_r0", a_q[31:0], 32'h0);
      tick();
    end
    a_we = 1'b0; a_wn = 5'd9; a_d = 32'h0;
    for (int n = 0; n < 32; n++) begin
      a_rn = {5'((n + 1) % 32), 5'(n)};
      @(negedge clk);
      chk_a("readback");
      tick();
    end
    a_rn = {5'd0, 5'd9};
    @(negedge clk);
    chk("we_low_r9", a_q[31:0], 32'hffff0009);
    tick();

    // bypass vs. no bypass
    a_we = 1'b1; a_wn = 5'd7; a_d = 32'hAAAA;
    c_we = 1'b1; c_wn = 5'd7; c_d = 32'hAAAA;
    tick();
    a_d = 32'h5555; c_d = 32'h5555;
    a_rn = {5'd7, 5'd7}; c_rn = {5'd0, 5'd7};
    @(negedge clk);
    chk("bypass_a", a_q[31:0], 32'h5555);
    chk("nobypass_c", c_q[31:0], 32'hAAAA);
    chk_a("bypass");
    tick();
    a_we = 1'b0; c_we = 1'b0;
    @(negedge clk);
    chk("after_c", c_q[31:0], 32'h5555);
    chk("after_a", a_q[31:0], 32'h5555);
    tick();

    // scoreboard
    a_bset = 1'b1; a_bn = 5'd3; a_rn = {5'd3, 5'd3};
    @(negedge clk);
    chk("sb_set_cycle", 32'(a_busy), 32'h0);
    tick();
    a_bset = 1'b0;
    @(negedge clk);
    chk("sb_busy", 32'(a_busy), 32'h3);
    chk_a("sb");
    tick();
    a_we = 1'b1; a_wn = 5'd3; a_d = 32'h3333;
    @(negedge clk);
    chk("sb_wr_cycle", 32'(a_busy), 32'h0);
    tick();
    a_we = 1'b0;
    @(negedge clk);
    chk("sb_cleared", 32'(a_busy), 32'h0);
    tick();
    a_we = 1'b1; a_bset = 1'b1; a_wn = 5'd3; a_bn = 5'd3;
    a_d = 32'h3A3A;
    tick();
    a_we = 1'b0; a_bset = 1'b0;
    @(negedge clk);
    chk("sb_both_busy", 32'(a_busy), 32'h3);
    chk("sb_both_q", a_q[31:0], 32'h3A3A);
    tick();

    // zero register
    a_we = 1'b1; a_wn = 5'd0; a_d = 32'hdeadbeef;
    a_bset = 1'b1; a_bn = 5'd0; a_rn = {5'd0, 5'd0};
    c_we = 1'b1; c_wn = 5'd0; c_d = 32'hdeadbeef;
    c_bset = 1'b1; c_bn = 5'd0; c_rn = {5'd0, 5'd0};
    @(negedge clk);
    chk("zero_q_wr", a_q[31:0], 32'h0);
    tick();
    a_we = 1'b0; a_bset = 1'b0; c_we = 1'b0; c_bset = 1'b0;
    @(negedge clk);
    chk("zero_q", a_q[31:0], 32'h0);
    chk("zero_busy", 32'(a_busy), 32'h0);
    chk("c_r0_q", c_q[31:0], 32'hdeadbeef);
    chk("c_r0_busy", 32'(c_busy[0]), 32'h1);
    tick();

    // small build: out-of-range addresses, four ports on one reg
    b_we = 1'b1; b_wn = 4'd4; b_d = 16'h4444;
    tick();
    b_wn = 4'd13; b_d = 16'hbeef; b_bset = 1'b1; b_bn = 4'd13;
    tick();
    b_we = 1'b0; b_bset = 1'b0;
    b_rn = {4{4'd4}};
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      chk("b_same_reg", 32'(b_q[p*16 +: 16]), 32'h4444);
    end
    chk("b_busy_4", 32'(b_busy), 32'h0);
    b_rn = {4'd13, 4'd12, 4'd0, 4'd4};
    @(negedge clk);
    chk("b_mix", 32'(b_q), 32'h4444);
    chk("b_hi", b_q[63:32], 32'h0);
    chk("b_busy_mix", 32'(b_busy), 32'h0);
    b_we = 1'b1; b_wn = 4'd11; b_d = 16'h1111; b_rn = {4'd0, 4'd0, 4'd0, 4'd11};
    @(negedge clk);
    chk("b_bypass", 32'(b_q[15:0]), 32'h1111);
    tick();
    b_we = 1'b0;

    // clear in the middle of traffic
    clr = 1'b1;
    a_we = 1'b1; a_wn = 5'd9; a_d = 32'h99;
    a_bset = 1'b1; a_bn = 5'd10;
    tick();
    clr = 1'b0; a_we = 1'b0; a_bset = 1'b0;
    a_rn = {5'd10, 5'd9};
    @(negedge clk);
    chk("clr_q", a_q[31:0], 32'h0);
    chk("clr_busy", 32'(a_busy), 32'h0);
    chk_a("clr");
    tick();

    // random traffic against the model
    for (int it = 0; it < 400; it++) begin
      clr    = ($urandom_range(0, 63) == 0);
      a_we   = 1'($urandom);
      a_wn   = 5'($urandom);
      a_d    = $urandom;
      a_bset = ($urandom_range(0, 3) == 0);
      a_bn   = 5'($urandom);
      a_rn[4:0] = ($urandom_range(0, 2) == 0) ? a_wn : 5'($urandom);
      a_rn[9:5] = ($urandom_range(0, 3) == 0) ? a_bn : 5'($urandom);
      @(negedge clk);
      chk_a("rand");
      tick();
    end
    clr = 1'b0; a_we = 1'b0; a_bset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
